// File: rtl/rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// rr_arbiter_lock
//
// N-way round-robin arbiter with a registered one-hot grant and grant lock.
// The current owner keeps the grant for as long as its request stays high.
// When other requesters are waiting, MAX_HOLD limits how many consecutive
// cycles one owner may keep the grant. Meant for shared resources such as an
// FPU issue port or a bus master mux, where ownership lasts several cycles.
//
// Parameters
//   N         number of requesters (>= 2)
//   MAX_HOLD  max consecutive grant cycles per owner while others wait;
//             0 = unlimited
//   IDXW      width of grant_idx, derived from N (do not override)
//
// Ports
//   clk          in   1     clock, rising edge
//   rst          in   1     asynchronous, active-low reset
//   req          in   N     request vector, bit i = requester i
//   prio         in   N     high-priority qualifier (RR_ARB_PRIO_EN only)
//   grant        out  N     one-hot grant, registered
//   grant_valid  out  1     |grant, registered
//   grant_idx    out  IDXW  binary index of the owner, 0 when idle
//
// Optional feature
//   RR_ARB_PRIO_EN  When defined, the prio port exists. Arbitration runs over
//                   req & prio whenever that is non-zero, and over req
//                   otherwise. It uses the same pointer and the same rotation
//                   rule. The low class may starve.
// -----------------------------------------------------------------------------
module rr_arbiter_lock #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
`ifdef RR_ARB_PRIO_EN
  input  logic [N-1:0]    prio,
`endif
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // The hold counter only has to reach MAX_HOLD-1, where it saturates.
  localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = (MAX_HOLD > 1) ? HCW'(MAX_HOLD - 1) : '0;
  localparam bit              HOLD_LIM  = (MAX_HOLD != 0);

  // The scan position needs one extra bit so that ptr + offset never
  // overflows before it wraps.
  localparam int              PW        = IDXW + 1;
  localparam logic [PW-1:0]   N_P       = PW'(N);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q,    state_d;
  logic [N-1:0]    grant_q,    grant_d;
  logic [IDXW-1:0] idx_q,      idx_d;
  logic [IDXW-1:0] ptr_q,      ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

  // ---------------------------------------------------------------------------
  // Active request class
  // ---------------------------------------------------------------------------
  logic [N-1:0] active_req;

`ifdef RR_ARB_PRIO_EN
  logic [N-1:0] hp_req;
  assign hp_req     = req & prio;
  assign active_req = (|hp_req) ? hp_req : req;
`else
  assign active_req = req;
`endif

  // ---------------------------------------------------------------------------
  // Rearbitration conditions
  // ---------------------------------------------------------------------------
  // grant_q is already the one-hot encoding of the owner, so it serves as the
  // owner mask without being decoded again.
  logic owner_req;
  logic others_waiting;
  logic timeout;
  logic rearb;

  assign owner_req      = |(req & grant_q);
  assign others_waiting = |(active_req & ~grant_q);
  assign timeout        = HOLD_LIM && (hold_cnt_q == HOLD_LAST) && others_waiting;
  assign rearb          = (state_q == ST_IDLE) || !owner_req || timeout;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first set bit of active_req, scanning from ptr_q
  // upward and wrapping modulo N.
  // ---------------------------------------------------------------------------
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [PW-1:0]   scan_pos;

  // NOTE: every variable written in an always_comb gets a default at the top.
  // Otherwise the block can leave it unassigned on some path and a latch is
  // inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_pos   = '0;
    for (int i = 0; i < N; i++) begin
      // NOTE: these are blocking assignments because scan_pos is a temporary
      // that is reused within the same pass. Registered state is only ever
      // written with <= in always_ff.
      scan_pos = {1'b0, ptr_q} + PW'(i);
      if (scan_pos >= N_P) begin
        scan_pos = scan_pos - N_P;
      end
      if (!pick_found && active_req[scan_pos[IDXW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_pos[IDXW-1:0];
      end
    end
  end

  // The pointer moves to the slot just past the winner. A timed-out owner is
  // therefore visited last on the next scan.
  logic [IDXW-1:0] ptr_next;
  assign ptr_next = (pick_idx == IDXW'(N - 1)) ? '0 : pick_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    if (rearb) begin
      hold_cnt_d = '0;
      if (pick_found) begin
        state_d = ST_OWNED;
        grant_d = N'(1) << pick_idx;
        idx_d   = pick_idx;
        ptr_d   = ptr_next;
      end else begin
        // Nobody is requesting. The pointer keeps its value, so fairness
        // carries over the idle period.
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    end else if (HOLD_LIM && (hold_cnt_q != HOLD_LAST)) begin
      // A sole requester is never preempted. The counter simply parks at
      // MAX_HOLD-1 until somebody else shows up.
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous, so the outputs drop as soon as rst goes low.
  // That includes the middle of a burst; the burst is not completed first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: every output comes straight from a flop, so there is no
  // combinational path from req to grant.
  // ---------------------------------------------------------------------------
  assign grant       = grant_q;
  assign grant_valid = (state_q == ST_OWNED);
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_lock
//
// Self-checking bench for rr_arbiter_lock (N=4, MAX_HOLD=4). It runs directed
// scenarios (reset, rotation, lock/release, hand-over, async reset mid-burst)
// and then a randomized phase. Every cycle is compared against a behavioural
// model that tracks the owner, the scan pointer and the length of the current
// ownership as plain integers.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_lock;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDXW     = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    prio;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;

  int n_checks;
  int n_errors;

  // Behavioural model state
  int m_owner;   // -1 when idle
  int m_ptr;     // next index to scan from
  int m_held;    // cycles the current owner has held the grant so far

  rr_arbiter_lock #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
`ifdef RR_ARB_PRIO_EN
    .prio        (prio),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounds the run in case something goes wrong with the clocking.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] act;
    logic [N-1:0] others;
    bit           go;
    int           win;
    act = r;
`ifdef RR_ARB_PRIO_EN
    if ((r & p) != 0) act = r & p;
`endif
    others = act;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    go = (m_owner < 0) || !r[m_owner] ||
         (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 0);
    if (go) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && act[j]) win = j;
      end
      if (win < 0) begin
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_owner = win;
        m_ptr   = (win + 1) % N;
        m_held  = 1;
      end
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [31:0] exp_grant();
    return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, ".grant"},       32'(grant),       exp_grant());
    check({tag, ".grant_valid"}, 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, ".grant_idx"},   32'(grant_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".onehot0"},     32'($onehot0(grant)), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Each task starts and ends at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] p, input string tag);
    req  = r;
    prio = p;
    @(posedge clk);
    model_edge(r, p);
    #1;
    compare_outputs(tag);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req  = 4'b1111;
    prio = 4'b0000;
    rst  = 1'b0;
    model_reset();
    #1;
    compare_outputs("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_outputs("reset_held");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b0;
    req  = '0;
    prio = '0;
    model_reset();
    @(negedge clk);

    // Reset with every requester active, then rotation under full load.
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1111, 4'b0000, "rotation");
      check("rotation.const", 32'(grant), 32'd1 << ((c / 4) % 4));
    end

    // Lock/release: req=0100 for 3 cycles, then idle. The pointer ends at 3,
    // so full load afterwards must start at requester 3.
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0100, 4'b0000, "lock");
      check("lock.const", 32'(grant), 32'h4);
    end
    cycle(4'b0000, 4'b0000, "release");
    check("release.const", 32'(grant), 32'h0);
    cycle(4'b1111, 4'b0000, "ptr_after_release");
    check("ptr_after_release.const", 32'(grant), 32'h8);

    // Wrap and hand-over: owner 1 drops its request while 0 waits.
    apply_reset();
    cycle(4'b0010, 4'b0000, "handover_setup");
    cycle(4'b0011, 4'b0000, "handover_hold");
    cycle(4'b0011, 4'b0000, "handover_hold");
    check("handover_hold.const", 32'(grant), 32'h2);
    cycle(4'b0001, 4'b0000, "handover");
    check("handover.const", 32'(grant), 32'h1);

    // Async reset mid-burst: outputs clear with no clock edge.
    apply_reset();
    for (int c = 0; c < 5; c++) cycle(4'b1111, 4'b0000, "burst");
    check("burst.const", 32'(grant), 32'h2);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("midburst_reset.grant", 32'(grant), 32'h0);
    check("midburst_reset.valid", 32'(grant_valid), 32'h0);
    check("midburst_reset.idx",   32'(grant_idx), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b1111, 4'b0000, "after_reset");
    check("after_reset.const", 32'(grant), 32'h1);

`ifdef RR_ARB_PRIO_EN
    // High class holds through timeouts; dropping prio resumes rotation.
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(4'b1111, 4'b1000, "prio_hold");
      check("prio_hold.const", 32'(grant), 32'h8);
    end
    for (int c = 0; c < 8; c++) cycle(4'b1111, 4'b0000, "prio_release");
`endif

    // Randomized phase: dense, sparse and single-requester patterns, with
    // occasional bursts where the same request vector is held.
    apply_reset();
    begin
      logic [N-1:0] r;
      logic [N-1:0] p;
      r = '0;
      p = '0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 3))
            0: r = N'($urandom);
            1: r = N'($urandom) & N'($urandom);
            2: r = N'(1) << $urandom_range(0, N - 1);
            default: r = N'($urandom) | N'($urandom);
          endcase
        end
`ifdef RR_ARB_PRIO_EN
        if ($urandom_range(0, 7) == 0) p = N'($urandom) & N'($urandom);
`endif
        cycle(r, p, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
